// File: rtl/dsp_job_scheduler_pkg.sv
// Shared types for the DSP job scheduler: FSM states, engine encodings and the
// queued job record (buffer id plus config-mode snapshot).
package dsp_sched_pkg;

    localparam int JOB_MODE_W = 5;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_ENG   = 3'd2,
        LAUNCH_DMA = 3'd3,
        WAIT_DMA   = 3'd4,
        RELEASE    = 3'd5
    } state_t;

    localparam logic ENG_FIR = 1'b0;
    localparam logic ENG_FFT = 1'b1;

    // "buf" is a reserved gate keyword, hence buf_id.
    typedef struct packed {
        logic                  buf_id;
        logic [JOB_MODE_W-1:0] mode;
    } job_t;

endpackage

// File: rtl/dsp_job_scheduler_if.sv
// Job request channel: a filled buffer announces itself with its id and the
// config-mode snapshot; req_ready reports room in the job queue.
interface dsp_job_scheduler_if #(
    parameter int MODE_W = 5
) ();

    logic              req_valid;
    logic              req_buf;
    logic [MODE_W-1:0] req_mode;
    logic              req_ready;

    modport master (
        output req_valid,
        output req_buf,
        output req_mode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_buf,
        input  req_mode,
        output req_ready
    );

endinterface

// File: rtl/dsp_job_scheduler_fifo.sv
// Synchronous job queue with wrap-around pointers; head entry is readable
// whenever the queue is non-empty.
module sched_fifo
    import dsp_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  job_t                     wdata_i,
    input  logic                     pop_i,
    output job_t                     rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    job_t           mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           push_ok_s;
    logic           pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == CW'(0));
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Storage array; contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dsp_job_scheduler.sv
// Queues buffer-full jobs and walks each through engine start, DMA start and
// buffer release, with a per-wait timeout and a sticky error flag.
module dsp_job_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int MODE_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    dsp_job_scheduler_if.slave       req,
    output logic                     start_fir,
    output logic                     start_fft,
    input  logic                     fir_done,
    input  logic                     fft_done,
    output logic                     start_dma_out,
    input  logic                     dma_done,
    output logic                     active_buf,
    output logic                     release_valid,
    output logic                     release_buf,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic                     err_clear,
    output logic [7:0]               jobs_done
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q;
    logic                eng_q;
    logic                active_buf_q;
    logic                release_buf_q;
    logic                release_valid_q;
    logic                start_fir_q;
    logic                start_fft_q;
    logic                start_dma_q;
    logic                timeout_err_q;
    logic                timed_out_q;
    logic [CNT_W-1:0]    to_cnt_q;
    logic [7:0]          jobs_done_q;

    job_t                push_job_s;
    job_t                head_job_s;
    logic                push_s;
    logic                pop_s;
    logic                full_s;
    logic                empty_s;
    logic [$clog2(DEPTH):0] count_s;
    logic                eng_done_s;
    logic                mode_unused_s;

    assign push_job_s.buf_id = req.req_buf;
    assign push_job_s.mode   = JOB_MODE_W'(req.req_mode[MODE_W-1:0]);
    assign push_s            = req.req_valid && !full_s;
    assign pop_s             = (state_q == IDLE) && !empty_s;
    assign req.req_ready     = !full_s;
    // Only bit 0 steers routing; the rest of the snapshot travels unused.
    assign mode_unused_s     = ^head_job_s.mode;

    sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (push_job_s),
        .pop_i   (pop_s),
        .rdata_o (head_job_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    assign eng_done_s = (eng_q == ENG_FFT) ? fft_done : fir_done;

    // Job sequencer with timeout supervision and registered control pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            eng_q           <= ENG_FIR;
            active_buf_q    <= 1'b0;
            release_buf_q   <= 1'b0;
            release_valid_q <= 1'b0;
            start_fir_q     <= 1'b0;
            start_fft_q     <= 1'b0;
            start_dma_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
            timed_out_q     <= 1'b0;
            to_cnt_q        <= CNT_W'(0);
            jobs_done_q     <= 8'd0;
        end else begin
            start_fir_q     <= 1'b0;
            start_fft_q     <= 1'b0;
            start_dma_q     <= 1'b0;
            release_valid_q <= 1'b0;
            if (err_clear) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!empty_s) begin
                        active_buf_q <= head_job_s.buf_id;
                        eng_q        <= head_job_s.mode[0];
                        start_fir_q  <= (head_job_s.mode[0] == ENG_FIR);
                        start_fft_q  <= (head_job_s.mode[0] == ENG_FFT);
                        state_q      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    to_cnt_q <= CNT_W'(0);
                    state_q  <= WAIT_ENG;
                end
                WAIT_ENG: begin
                    if (eng_done_s) begin
                        start_dma_q <= 1'b1;
                        state_q     <= LAUNCH_DMA;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_err_q   <= 1'b1;
                        timed_out_q     <= 1'b1;
                        release_valid_q <= 1'b1;
                        release_buf_q   <= active_buf_q;
                        state_q         <= RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end
                LAUNCH_DMA: begin
                    to_cnt_q <= CNT_W'(0);
                    state_q  <= WAIT_DMA;
                end
                WAIT_DMA: begin
                    if (dma_done) begin
                        release_valid_q <= 1'b1;
                        release_buf_q   <= active_buf_q;
                        state_q         <= RELEASE;
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_err_q   <= 1'b1;
                        timed_out_q     <= 1'b1;
                        release_valid_q <= 1'b1;
                        release_buf_q   <= active_buf_q;
                        state_q         <= RELEASE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!timed_out_q) begin
                        jobs_done_q <= jobs_done_q + 8'd1;
                    end
                    timed_out_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_fir     = start_fir_q;
    assign start_fft     = start_fft_q;
    assign start_dma_out = start_dma_q;
    assign active_buf    = active_buf_q;
    assign release_valid = release_valid_q;
    assign release_buf   = release_buf_q;
    assign timeout_err   = timeout_err_q;
    assign jobs_done     = jobs_done_q;
    assign busy          = (state_q != IDLE) || (count_s != ($clog2(DEPTH)+1)'(0));

endmodule

// File: tb/tb_dsp_job_scheduler.sv
// Scoreboarded bench for dsp_job_scheduler: directed jobs push expected engine
// starts and buffer releases; a negedge monitor pops and compares them.
module tb_dsp_job_scheduler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int MODE_W  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fir_done = 1'b0;
    logic       fft_done = 1'b0;
    logic       dma_done = 1'b0;
    logic       err_clear = 1'b0;
    logic       start_fir, start_fft, start_dma_out;
    logic       active_buf, release_valid, release_buf, busy, timeout_err;
    logic [7:0] jobs_done;
    logic [15:0] outs_s;

    int tests_run = 0;
    int tests_failed = 0;
    bit exp_eng_q[$];
    bit exp_rel_q[$];

    always #5 clk = ~clk;

    dsp_job_scheduler_if #(.MODE_W(MODE_W)) rif ();

    dsp_job_scheduler #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .MODE_W  (MODE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (rif.slave),
        .start_fir     (start_fir),
        .start_fft     (start_fft),
        .fir_done      (fir_done),
        .fft_done      (fft_done),
        .start_dma_out (start_dma_out),
        .dma_done      (dma_done),
        .active_buf    (active_buf),
        .release_valid (release_valid),
        .release_buf   (release_buf),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .err_clear     (err_clear),
        .jobs_done     (jobs_done)
    );

    assign outs_s = {start_fir, start_fft, start_dma_out, release_valid,
                     release_buf, active_buf, busy, timeout_err, jobs_done};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input bit b, input logic [MODE_W-1:0] mode,
                            input bit exp_start, input bit exp_rel);
        rif.req_valid = 1'b1;
        rif.req_buf   = b;
        rif.req_mode  = mode;
        if (exp_start) exp_eng_q.push_back(mode[0]);
        if (exp_rel)   exp_rel_q.push_back(b);
        tick();
        rif.req_valid = 1'b0;
    endtask

    // Called in a WAIT_ENG cycle; returns in the following IDLE cycle.
    task automatic finish_job(input bit fft);
        if (fft) fft_done = 1'b1; else fir_done = 1'b1;
        tick();
        fft_done = 1'b0;
        fir_done = 1'b0;
        chk("dma_start", 32'(start_dma_out), 32'd1);
        tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("release_pulse", 32'(release_valid), 32'd1);
        tick();
    endtask

    task automatic wait_launch();
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 50) begin
            tick();
            n++;
            seen = start_fir || start_fft;
        end
        chk("wait_launch", 32'(seen), 32'd1);
    endtask

    task automatic run_job(input bit fft);
        wait_launch();
        tick();
        finish_job(fft);
    endtask

    // Scoreboard monitor: every start/release pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (start_fir || start_fft) begin
            if (exp_eng_q.size() == 0) begin
                chk("unexpected_start", {30'd0, start_fft, start_fir}, 32'd0);
            end else begin
                bit e;
                e = exp_eng_q.pop_front();
                chk("start_engine", {30'd0, start_fft, start_fir}, e ? 32'd2 : 32'd1);
            end
        end
        if (release_valid) begin
            if (exp_rel_q.size() == 0) begin
                chk("unexpected_release", 32'(release_valid), 32'd0);
            end else begin
                bit e;
                e = exp_rel_q.pop_front();
                chk("release_buf", 32'(release_buf), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.req_valid = 1'b0;
        rif.req_buf   = 1'b0;
        rif.req_mode  = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_outputs", 32'(outs_s), 32'd0);
        chk("reset_req_ready", 32'(rif.req_ready), 32'd1);

        // One FIR job, fir_done ten cycles after start.
        push_req(1'b1, 5'b00000, 1'b1, 1'b1);
        tick();
        chk("t1_start_fir", 32'(start_fir), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        repeat (9) tick();
        fir_done = 1'b1;
        tick();
        fir_done = 1'b0;
        chk("t1_dma_latency", 32'(start_dma_out), 32'd1);
        tick();
        chk("t1_dma_one_shot", 32'(start_dma_out), 32'd0);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("t1_release", 32'(release_valid), 32'd1);
        tick();
        chk("t1_jobs_done", 32'(jobs_done), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Fill the queue with engines held off; a sixth request is dropped.
        push_req(1'b0, 5'b00000, 1'b1, 1'b1);
        push_req(1'b1, 5'b00000, 1'b1, 1'b1);
        push_req(1'b0, 5'b00000, 1'b1, 1'b1);
        push_req(1'b1, 5'b00000, 1'b1, 1'b1);
        push_req(1'b0, 5'b00000, 1'b1, 1'b1);
        chk("t2_ready_low", 32'(rif.req_ready), 32'd0);
        chk("t2_count_full", 32'(dut.u_fifo.count_o), 32'd4);
        push_req(1'b1, 5'b00000, 1'b0, 1'b0);
        chk("t2_drop_count", 32'(dut.u_fifo.count_o), 32'd4);
        finish_job(1'b0);
        for (int i = 0; i < 4; i++) run_job(1'b0);
        chk("t2_jobs_done", 32'(jobs_done), 32'd6);
        chk("t2_idle_busy", 32'(busy), 32'd0);

        // FFT routing; done during LAUNCH and stray fir_done are ignored.
        push_req(1'b0, 5'b00001, 1'b1, 1'b1);
        tick();
        chk("t3_start_fft", 32'({start_fft, start_fir}), 32'd2);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        chk("t3_launch_done_ignored", 32'(start_dma_out), 32'd0);
        fir_done = 1'b1;
        tick();
        fir_done = 1'b0;
        chk("t3_stray_fir", 32'(start_dma_out), 32'd0);
        finish_job(1'b1);
        chk("t3_jobs_done", 32'(jobs_done), 32'd7);

        // Timeout in WAIT_ENG, then clear.
        push_req(1'b1, 5'b00011, 1'b1, 1'b1);
        tick();
        chk("t4_start_fft", 32'(start_fft), 32'd1);
        repeat (16) tick();
        chk("t4_no_err_yet", 32'({timeout_err, release_valid}), 32'd0);
        tick();
        chk("t4_timeout_err", 32'(timeout_err), 32'd1);
        chk("t4_release", 32'(release_valid), 32'd1);
        tick();
        chk("t4_jobs_unchanged", 32'(jobs_done), 32'd7);
        chk("t4_err_sticky", 32'(timeout_err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t4_err_cleared", 32'(timeout_err), 32'd0);

        // Push and pop on one edge at count 2; done on the threshold cycle.
        push_req(1'b1, 5'b00000, 1'b1, 1'b1);
        push_req(1'b0, 5'b00000, 1'b1, 1'b1);
        push_req(1'b1, 5'b00000, 1'b1, 1'b1);
        chk("t5_count_two", 32'(dut.u_fifo.count_o), 32'd2);
        finish_job(1'b0);
        chk("t5_count_pre", 32'(dut.u_fifo.count_o), 32'd2);
        push_req(1'b0, 5'b00000, 1'b1, 1'b1);
        chk("t5_push_pop_count", 32'(dut.u_fifo.count_o), 32'd2);
        chk("t5_next_launch", 32'(start_fir), 32'd1);
        repeat (16) tick();
        finish_job(1'b0);
        chk("t5_threshold_no_err", 32'(timeout_err), 32'd0);
        chk("t5_threshold_success", 32'(jobs_done), 32'd9);
        run_job(1'b0);
        run_job(1'b0);
        chk("t5_jobs_done", 32'(jobs_done), 32'd11);

        // Reset during WAIT_DMA with two jobs queued.
        push_req(1'b0, 5'b00000, 1'b1, 1'b0);
        push_req(1'b1, 5'b00000, 1'b0, 1'b0);
        push_req(1'b0, 5'b00001, 1'b0, 1'b0);
        fir_done = 1'b1;
        tick();
        fir_done = 1'b0;
        chk("t6_dma_start", 32'(start_dma_out), 32'd1);
        tick();
        chk("t6_count_two", 32'(dut.u_fifo.count_o), 32'd2);
        reset = 1'b1;
        tick();
        chk("t6_reset_outputs", 32'(outs_s), 32'd0);
        chk("t6_reset_count", 32'(dut.u_fifo.count_o), 32'd0);
        reset = 1'b0;
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        repeat (4) tick();
        chk("t6_stays_idle", 32'(outs_s), 32'd0);

        chk("sb_starts_drained", 32'(exp_eng_q.size()), 32'd0);
        chk("sb_releases_drained", 32'(exp_rel_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dsp_job_scheduler.md
# dsp_job_scheduler

Sequences the shared DSP datapath (FIR/FFT engines, then DMA out) for the ping-pong input buffers. Buffer-full events enter a small job queue, together with their buffer id and a snapshot of the config mode. Each job is dispatched to the engine selected by the mode, then to DMA, and the buffer is released afterwards. The block sits between the input buffer/config register and the engine, clock-manager and DMA start lines, and replaces the single-shot sequencing in the current controller.

## Interface
Parameters:
- DEPTH, 4 — job queue entries (power of two, ≥2)
- TIMEOUT, 1024 — max cycles waiting for any done
- MODE_W, 5 — config mode width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  job request (buffer filled)
- req_buf  in  1  buffer id of request
- req_mode  in  MODE_W  config snapshot; bit0: 0=FIR, 1=FFT
- req_ready  out  1  queue not full
- start_fir  out  1  one-cycle FIR start pulse
- start_fft  out  1  one-cycle FFT start pulse
- fir_done  in  1  FIR completion
- fft_done  in  1  FFT completion
- start_dma_out  out  1  one-cycle DMA start pulse
- dma_done  in  1  DMA completion
- active_buf  out  1  buffer id of job in service (drives buffer mux)
- release_valid  out  1  one-cycle buffer-free pulse
- release_buf  out  1  buffer id being freed
- busy  out  1  state≠IDLE or queue non-empty
- timeout_err  out  1  sticky error flag
- err_clear  in  1  clears timeout_err
- jobs_done  out  8  successful-job counter, wraps 255→0

## Operation
- Reset values: every output is 0; queue empty; state IDLE; timeout counter 0.
- Queue: a request is pushed at the edge where req_valid && req_ready. req_ready = !full, derived from the registered count only; a request while full is dropped (no push). Push and pop on the same edge are legal; count is unchanged.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head, latch buf/mode, go to LAUNCH.
  - LAUNCH: assert start_fir (mode[0]=0) or start_fft (mode[0]=1); go to WAIT_ENG.
  - WAIT_ENG: wait for the selected engine's done. On done, go to LAUNCH_DMA. The other engine's done is ignored.
  - LAUNCH_DMA: assert start_dma_out; go to WAIT_DMA.
  - WAIT_DMA: on dma_done, go to RELEASE.
  - RELEASE: pulse release_valid with release_buf = latched buf; return to IDLE.
- Timeout: the counter clears on entry to WAIT_ENG and WAIT_DMA and increments each cycle in them. When it reaches TIMEOUT-1 without done, set timeout_err and go to RELEASE. The job is abandoned, the buffer is still released, and jobs_done does not increment.
- jobs_done increments in RELEASE only for jobs that did not time out.
- timeout_err stays high until err_clear. If err_clear and a new timeout occur in the same cycle, the set wins.
- done inputs are ignored outside their wait state, including a done coincident with LAUNCH or LAUNCH_DMA.
- A done in the same cycle as the timeout threshold counts as success; the done wins.
- active_buf holds the latched buf from the pop until the next pop.
- Reset mid-job: immediate return to reset values. The queue is flushed and no release pulse is issued.

## Timing
- All outputs are registered or pure Moore decodes of state; there is no combinational input→output path.
- Empty queue, IDLE, request accepted at edge E: IDLE pops at E+1, start_* is high in the cycle after E+1 (LAUNCH), and WAIT_ENG begins at E+3.
- Done sampled high at edge D: start_dma_out is high in the cycle after D. dma_done sampled at edge D2: release_valid is high in the cycle after D2, and IDLE follows.
- Minimum job length, with done arriving on the first WAIT cycle: 6 cycles from pop to IDLE.
- Back-to-back jobs: the next pop happens at the IDLE edge directly after RELEASE. There is no bubble beyond IDLE.

## Structure
- Package dsp_sched_pkg holds:
  - state_t enum (IDLE, LAUNCH, WAIT_ENG, LAUNCH_DMA, WAIT_DMA, RELEASE)
  - ENG_FIR=1'b0 and ENG_FFT=1'b1
  - job_t struct {buf, mode}
- Sub-module sched_fifo: synchronous FIFO of job_t, DEPTH entries, with full/empty/count outputs and wrap-around pointers. The FSM, timeout counter and counters stay in dsp_job_scheduler.

## Test plan
- Reset, then one FIR job: buf=1, mode=5'b00000; fir_done 10 cycles after start → exactly one start_fir pulse, start_dma_out, then dma_done → release_valid with release_buf=1, jobs_done=1, busy=0.
- Fill: push 5 requests back-to-back with DEPTH=4 and done withheld → the first is popped, 4 are queued, and req_ready drops. A push while full leaves count at 4. After completions, all accepted jobs are released in order: buf ids 0,1,0,1,0.
- FFT routing: mode bit0=1 → start_fft only. A stray fir_done during WAIT_ENG causes no transition; fft_done advances the FSM.
- Timeout with TIMEOUT=16: no fft_done → timeout_err=1 after 16 WAIT_ENG cycles, release pulse issued, jobs_done unchanged. Then err_clear → timeout_err=0.
- Reset asserted in WAIT_DMA with 2 jobs queued → all outputs 0 next cycle, no release pulse, and a later dma_done is ignored.
- Simultaneous push and pop at count=2 → count stays at 2. fir_done asserted on the exact threshold cycle → success, and jobs_done increments.
